// File: rtl/instr_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
// A fetch is accepted on a rising edge where mem_req and mem_ready are both high.
interface instr_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/WB controller for the 16-bit datapath.
// Holds pc, the instruction register and the retired-instruction count.
module instr_sequencer #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  instr_sequencer_if.master   mem,
  output logic [3:0]          opcode,
  output logic [3:0]          opext,
  output logic [REGBITS-1:0]  ra1,
  output logic [REGBITS-1:0]  ra2,
  output logic [REGBITS-1:0]  wa,
  output logic [7:0]          imm,
  output logic                imm_sel,
  output logic                regwrite,
  output logic                halted,
  output logic [WIDTH-1:0]    retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] retired_q;
  logic             mem_req_q;
  logic             regwrite_q;
  logic             halted_q;
  logic             is_cmp;

  // Instruction fields are pure slices of ir, stable from DECODE through WB.
  assign opcode  = ir_q[15:12];
  assign opext   = ir_q[7:4];
  assign ra1     = ir_q[8 +: REGBITS];
  assign ra2     = ir_q[0 +: REGBITS];
  assign wa      = ir_q[8 +: REGBITS];
  assign imm     = ir_q[7:0];
  assign imm_sel = (opcode != 4'b0000);

  assign is_cmp = ((opcode == 4'b0000) && (opext == 4'b1011)) || (opcode == 4'b1011);

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = pc_q;
  assign regwrite     = regwrite_q;
  assign halted       = halted_q;
  assign retired      = retired_q;

  // Moore outputs are registered alongside the state: each transition loads
  // the output values belonging to the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      retired_q  <= '0;
      mem_req_q  <= 1'b0;
      regwrite_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all reads see pre-edge values,
      // independent of statement order inside the block.
      case (state_q)
        S_IDLE: begin
          state_q   <= S_FETCH;
          mem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (mem.mem_ready) begin
            ir_q      <= mem.mem_rdata;
            pc_q      <= pc_q + 1'b1;
            state_q   <= S_DECODE;
            mem_req_q <= 1'b0;
          end
        end
        S_DECODE: begin
          if (ir_q == '1) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q    <= S_WB;
          regwrite_q <= !is_cmp;
        end
        S_WB: begin
          regwrite_q <= 1'b0;
          retired_q  <= retired_q + 1'b1;
          state_q    <= S_FETCH;
          mem_req_q  <= 1'b1;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q    <= S_IDLE;
          mem_req_q  <= 1'b0;
          regwrite_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a table of single-instruction vectors
// plus hand-written sequences for wait states, compares, halt, reset and pc wrap.
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic [3:0]  opcode;
  logic [3:0]  opext;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [3:0]  wa;
  logic [7:0]  imm;
  logic        imm_sel;
  logic        regwrite;
  logic        halted;
  logic [15:0] retired;

  int checks   = 0;
  int failures = 0;

  instr_sequencer_if #(.WIDTH(16)) mem_bus ();

  instr_sequencer #(.WIDTH(16), .REGBITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem      (mem_bus),
    .opcode   (opcode),
    .opext    (opext),
    .ra1      (ra1),
    .ra2      (ra2),
    .wa       (wa),
    .imm      (imm),
    .imm_sel  (imm_sel),
    .regwrite (regwrite),
    .halted   (halted),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  op;
    logic [3:0]  ext;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [3:0]  w;
    logic [7:0]  im;
    logic        sel;
    logic        rw;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req",  32'(mem_bus.mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
    check("rst_regwrite", 32'(regwrite), 32'd0);
    check("rst_halted",   32'(halted), 32'd0);
    check("rst_retired",  32'(retired), 32'd0);
    check("rst_fields",   {opcode, opext, ra1, ra2, wa, imm, 3'b0, imm_sel}, 32'd0);
    reset = 1'b1;
  endtask

  vec_t vecs [5];
  logic [15:0] glitch [4];
  int acc [4];
  int n_acc;
  int rw_cnt;
  int bad;

  initial begin
    vecs[0] = '{16'h0152, 4'h0, 4'h5, 4'h1, 4'h2, 4'h1, 8'h52, 1'b0, 1'b1};
    vecs[1] = '{16'h5307, 4'h5, 4'h0, 4'h3, 4'h7, 4'h3, 8'h07, 1'b1, 1'b1};
    vecs[2] = '{16'h0BB4, 4'h0, 4'hB, 4'hB, 4'h4, 4'hB, 8'hB4, 1'b0, 1'b0};
    vecs[3] = '{16'hB4FF, 4'hB, 4'hF, 4'h4, 4'hF, 4'h4, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{16'h1234, 4'h1, 4'h3, 4'h2, 4'h4, 4'h2, 8'h34, 1'b1, 1'b1};
    glitch[0] = 16'hA5C3;
    glitch[1] = 16'h3C5A;
    glitch[2] = 16'hFFFF;
    glitch[3] = 16'h8001;

    // Single-instruction vectors, mem_ready tied high.
    for (int v = 0; v < 5; v++) begin
      reset_dut();
      mem_bus.mem_rdata = vecs[v].instr;
      mem_bus.mem_ready = 1'b1;
      step();
      check("c1_mem_req",  32'(mem_bus.mem_req), 32'd1);
      check("c1_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
      step();
      check("dec_mem_req", 32'(mem_bus.mem_req), 32'd0);
      check("dec_regwrite", 32'(regwrite), 32'd0);
      step();
      check("exec_regwrite", 32'(regwrite), 32'd0);
      step();
      check("wb_regwrite", 32'(regwrite), 32'(vecs[v].rw));
      check("wb_opcode",   32'(opcode), 32'(vecs[v].op));
      check("wb_opext",    32'(opext), 32'(vecs[v].ext));
      check("wb_ra1",      32'(ra1), 32'(vecs[v].r1));
      check("wb_ra2",      32'(ra2), 32'(vecs[v].r2));
      check("wb_wa",       32'(wa), 32'(vecs[v].w));
      check("wb_imm",      32'(imm), 32'(vecs[v].im));
      check("wb_imm_sel",  32'(imm_sel), 32'(vecs[v].sel));
      step();
      check("f2_regwrite", 32'(regwrite), 32'd0);
      check("f2_retired",  32'(retired), 32'd1);
      check("f2_mem_addr", 32'(mem_bus.mem_addr), 32'd1);
      check("f2_mem_req",  32'(mem_bus.mem_req), 32'd1);
    end

    // CMP then CMPI back to back: no writes, two retirements, 4-cycle spacing.
    reset_dut();
    mem_bus.mem_rdata = 16'h0BB4;
    mem_bus.mem_ready = 1'b1;
    n_acc = 0;
    rw_cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      rw_cnt += int'(regwrite);
      if (mem_bus.mem_req && mem_bus.mem_ready && n_acc < 4) begin
        acc[n_acc] = c;
        n_acc++;
      end
      if (!mem_bus.mem_req && n_acc == 1) mem_bus.mem_rdata = 16'hB4FF;
    end
    check("cmp_acc_count", 32'(n_acc), 32'd3);
    check("cmp_acc_spacing", 32'(acc[1] - acc[0]), 32'd4);
    check("cmp_regwrite_cnt", 32'(rw_cnt), 32'd0);
    check("cmp_retired", 32'(retired), 32'd2);
    check("cmp_mem_addr", 32'(mem_bus.mem_addr), 32'd2);

    // Five cycles of mem_ready low with glitching data, accept on the sixth.
    reset_dut();
    step();
    for (int i = 0; i < 4; i++) begin
      mem_bus.mem_rdata = glitch[i];
      step();
      check("wait_mem_req",  32'(mem_bus.mem_req), 32'd1);
      check("wait_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
      check("wait_ir_hold",  32'({opcode, opext, imm}), 32'd0);
    end
    mem_bus.mem_rdata = 16'h0152;
    mem_bus.mem_ready = 1'b1;
    step();
    check("wait_accept", 32'(mem_bus.mem_req), 32'd0);
    mem_bus.mem_rdata = 16'h7777;
    step();
    step();
    check("wait_wb_regwrite", 32'(regwrite), 32'd1);
    check("wait_wb_wa", 32'(wa), 32'd1);
    check("wait_wb_ra2", 32'(ra2), 32'd2);

    // ADD then HALT; halt absorbs until async reset.
    reset_dut();
    mem_bus.mem_rdata = 16'h0152;
    mem_bus.mem_ready = 1'b1;
    step();
    step();
    mem_bus.mem_rdata = 16'hFFFF;
    repeat (4) step();
    check("halt_in_decode", 32'(halted), 32'd0);
    step();
    check("halt_set", 32'(halted), 32'd1);
    check("halt_mem_req", 32'(mem_bus.mem_req), 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_bus.mem_req || regwrite || !halted) bad++;
    end
    check("halt_absorbing", 32'(bad), 32'd0);
    check("halt_retired", 32'(retired), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("halt_async_clear", 32'(halted), 32'd0);
    check("halt_rst_retired", 32'(retired), 32'd0);
    reset = 1'b1;
    step();
    check("halt_restart_req", 32'(mem_bus.mem_req), 32'd1);
    check("halt_restart_addr", 32'(mem_bus.mem_addr), 32'd0);

    // Async reset during WB abandons the write.
    reset_dut();
    mem_bus.mem_rdata = 16'h0152;
    mem_bus.mem_ready = 1'b1;
    repeat (4) step();
    check("wbrst_pre_regwrite", 32'(regwrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("wbrst_regwrite", 32'(regwrite), 32'd0);
    check("wbrst_retired", 32'(retired), 32'd0);
    check("wbrst_pc", 32'(mem_bus.mem_addr), 32'd0);
    reset = 1'b1;
    step();
    check("wbrst_restart_req", 32'(mem_bus.mem_req), 32'd1);
    check("wbrst_restart_addr", 32'(mem_bus.mem_addr), 32'd0);

    // pc wrap: preload pc to 16'hFFFF while in DECODE, then fetch once more.
    reset_dut();
    mem_bus.mem_rdata = 16'h0000;
    mem_bus.mem_ready = 1'b1;
    step();
    step();
    force dut.pc_q = 16'hFFFF;
    #1;
    release dut.pc_q;
    check("wrap_preload", 32'(mem_bus.mem_addr), 32'hFFFF);
    repeat (3) step();
    check("wrap_fetch_addr", 32'(mem_bus.mem_addr), 32'hFFFF);
    check("wrap_fetch_req", 32'(mem_bus.mem_req), 32'd1);
    step();
    check("wrap_pc_zero", 32'(mem_bus.mem_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequences are short, so any overrun is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
